// File: rtl/ysyx_040978_div_ctrl_if.sv
// Request/response handshake plus the command/result channel to the iterative divider.
// The controller takes the slave view; the environment takes the master view.
interface ysyx_040978_div_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        is_word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic        dv_in_valid;
  logic        dv_signed;
  logic [63:0] dv_dividend;
  logic [63:0] dv_divisor;
  logic        dv_out_valid;
  logic [63:0] dv_quotient;
  logic [63:0] dv_remainder;

  modport slave (
    input  in_valid, op, is_word, src1, src2, out_ready,
    input  dv_out_valid, dv_quotient, dv_remainder,
    output in_ready, out_valid, out_result,
    output dv_in_valid, dv_signed, dv_dividend, dv_divisor
  );

  modport master (
    output in_valid, op, is_word, src1, src2, out_ready,
    output dv_out_valid, dv_quotient, dv_remainder,
    input  in_ready, out_valid, out_result,
    input  dv_in_valid, dv_signed, dv_dividend, dv_divisor
  );
endinterface

// File: rtl/ysyx_040978_div_ctrl.sv
// RV64 M-extension divide/remainder controller: prepares operands, resolves divide-by-zero
// and signed overflow locally, otherwise sequences one run of an external iterative divider.
module ysyx_040978_div_ctrl (
  input logic                   clock,
  input logic                   reset,
  ysyx_040978_div_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [63:0] MinS64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MinS32 = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q;
  logic        is_word_q;
  logic [63:0] dividend_q, divisor_q;
  logic [63:0] result_q, result_d;

  logic        accept;
  logic [63:0] dividend_p, divisor_p;
  logic        div_zero, overflow, special;
  logic [63:0] special_sel, special_res;
  logic [63:0] dv_sel, dv_res;

  // W-forms work on the low word, extended according to signedness.
  always_comb begin
    dividend_p = bus.src1;
    divisor_p  = bus.src2;
    if (bus.is_word) begin
      if (bus.op[0]) begin
        dividend_p = {32'b0, bus.src1[31:0]};
        divisor_p  = {32'b0, bus.src2[31:0]};
      end else begin
        dividend_p = {{32{bus.src1[31]}}, bus.src1[31:0]};
        divisor_p  = {{32{bus.src2[31]}}, bus.src2[31:0]};
      end
    end
  end

  assign accept   = bus.in_valid && (state_q == StIdle);
  assign div_zero = (divisor_p == 64'd0);
  assign overflow = !bus.op[0] && (divisor_p == AllOne) &&
                    (dividend_p == (bus.is_word ? MinS32 : MinS64));
  assign special  = div_zero || overflow;

  always_comb begin
    if (div_zero) special_sel = bus.op[1] ? dividend_p : AllOne;
    else          special_sel = bus.op[1] ? 64'd0 : dividend_p;
    special_res = bus.is_word ? {{32{special_sel[31]}}, special_sel[31:0]} : special_sel;
  end

  always_comb begin
    dv_sel = op_q[1] ? bus.dv_remainder : bus.dv_quotient;
    dv_res = is_word_q ? {{32{dv_sel[31]}}, dv_sel[31:0]} : dv_sel;
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (special) begin
            state_d  = StDone;
            result_d = special_res;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // Completion pulses are only meaningful while a run is outstanding.
        if (bus.dv_out_valid) begin
          state_d  = StDone;
          result_d = dv_res;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      is_word_q  <= 1'b0;
      dividend_q <= 64'd0;
      divisor_q  <= 64'd0;
      result_q   <= 64'd0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q       <= bus.op;
        is_word_q  <= bus.is_word;
        dividend_q <= dividend_p;
        divisor_q  <= divisor_p;
      end
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.out_result  = result_q;
  assign bus.dv_in_valid = (state_q == StIssue);
  assign bus.dv_signed   = ~op_q[0];
  assign bus.dv_dividend = dividend_q;
  assign bus.dv_divisor  = divisor_q;

endmodule

// File: tb/tb_ysyx_040978_div_ctrl.sv
// Directed bench for ysyx_040978_div_ctrl with a short-latency behavioural divider.
module tb_ysyx_040978_div_ctrl;
  localparam int DivLat = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   dv_pulses = 0;

  ysyx_040978_div_ctrl_if bus ();

  ysyx_040978_div_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural divider: fixed latency, shares the controller's reset.
  logic        m_busy;
  int          m_cnt;
  logic        m_signed;
  logic [63:0] m_a, m_b, last_dividend;
  logic        m_valid;
  logic        stray;
  logic signed [63:0] sa, sb;

  assign bus.dv_out_valid = m_valid | stray;

  always @(posedge clock) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
    end else begin
      m_valid <= 1'b0;
      if (bus.dv_in_valid) begin
        dv_pulses     <= dv_pulses + 1;
        m_busy        <= 1'b1;
        m_cnt         <= DivLat;
        m_signed      <= bus.dv_signed;
        m_a           <= bus.dv_dividend;
        m_b           <= bus.dv_divisor;
        last_dividend <= bus.dv_dividend;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          if (m_signed) begin
            sa = m_a;
            sb = m_b;
            bus.dv_quotient  <= sa / sb;
            bus.dv_remainder <= sa % sb;
          end else begin
            bus.dv_quotient  <= m_a / m_b;
            bus.dv_remainder <= m_a % m_b;
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the result, optionally acknowledge it.
  task automatic run_req(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] s1, input logic [63:0] s2,
                         input logic [63:0] exp, input logic special, input logic ack);
    int n;
    int p0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.is_word  = w;
    bus.src1     = s1;
    bus.src2     = s2;
    p0 = dv_pulses;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.src1     = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.src2     = 64'h0;
    chk({tag, "_issue"}, {63'd0, bus.dv_in_valid}, {63'd0, !special});
    n = 0;
    while (!bus.out_valid && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    if (special) chk({tag, "_lat"}, 64'(n), 64'd0);
    chk({tag, "_result"}, bus.out_result, exp);
    chk({tag, "_pulses"}, 64'(dv_pulses - p0), special ? 64'd0 : 64'd1);
    if (ack) begin
      bus.out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.out_ready = 1'b0;
      chk({tag, "_ready"}, {63'd0, bus.in_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [63:0] held;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.is_word   = 1'b0;
    bus.src1      = 64'd0;
    bus.src2      = 64'd0;
    bus.out_ready = 1'b0;
    bus.dv_quotient  = 64'd0;
    bus.dv_remainder = 64'd0;
    stray = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_dv_in_valid", {63'd0, bus.dv_in_valid}, 64'd0);
    chk("rst_out_result", bus.out_result, 64'd0);
    reset = 1'b0;

    // Stray completion pulse while idle must not produce a result.
    @(negedge clock);
    stray = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    chk("stray_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("stray_in_ready", {63'd0, bus.in_ready}, 64'd1);

    run_req("div_m7_2", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b1);
    run_req("rem_m7_2", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_req("divu_z", 2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_req("remu_z", 2'b11, 1'b0, 64'h1234, 64'd0, 64'h1234, 1'b1, 1'b1);
    run_req("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);
    run_req("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd0, 1'b1, 1'b1);
    run_req("divw_ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1);
    run_req("divw", 2'b00, 1'b1, 64'h0000_0001_8000_0000, 64'd2,
            64'hFFFF_FFFF_C000_0000, 1'b0, 1'b1);
    chk("divw_operand", last_dividend, 64'hFFFF_FFFF_8000_0000);
    run_req("divuw", 2'b01, 1'b1, 64'h0000_0001_8000_0000, 64'd2,
            64'h0000_0000_4000_0000, 1'b0, 1'b1);
    chk("divuw_operand", last_dividend, 64'h0000_0000_8000_0000);

    // Backpressure: result held, no new accept while in DONE.
    run_req("hold", 2'b01, 1'b0, 64'd1000, 64'd3, 64'd333, 1'b0, 1'b0);
    held = bus.out_result;
    bus.in_valid = 1'b1;
    bus.src1     = 64'd5;
    bus.src2     = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_result", bus.out_result, held);
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.out_ready = 1'b0;
    chk("release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    run_req("b2b_rem", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);

    // Reset while waiting on the divider abandons the request.
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.is_word  = 1'b0;
    bus.src1     = 64'd50;
    bus.src2     = 64'd5;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    @(negedge clock);
    chk("wait_in_ready", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    repeat (DivLat + 4) @(negedge clock);
    chk("mid_rst_no_result", {63'd0, bus.out_valid}, 64'd0);
    run_req("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_040978_div_ctrl.md
YSYX_040978_DIV_CTRL -- requirements
Module: ysyx_040978_div_ctrl

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 64 bits.
REQ-002 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  request valid.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (op[0]=unsigned, op[1]=remainder).
REQ-007 is_word  in  1  RV64 W-form: operate on low 32 bits, sign-extend the result.
REQ-008 src1  in  64  dividend operand.
REQ-009 src2  in  64  divisor operand.
REQ-010 out_valid  out  1  result valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_result  out  64  final quotient or remainder.
REQ-013 dv_in_valid  out  1  start pulse to the iterative 64-bit divider.
REQ-014 dv_signed  out  1  signed-divide select to the divider.
REQ-015 dv_dividend / dv_divisor  out  64 each  divider operands, driven from internal registers.
REQ-016 dv_out_valid  in  1  divider one-cycle completion pulse.
REQ-017 dv_quotient / dv_remainder  in  64 each  divider results; valid only in the dv_out_valid cycle.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid&in_ready.
REQ-020 On accept, the block SHALL register op, is_word and the prepared operands.
REQ-021 Operand preparation for is_word=1: sign-extend src[31:0] if op[0]=0, zero-extend src[31:0] if op[0]=1.
REQ-022 Operand preparation for is_word=0: pass src1/src2 through unchanged.
REQ-023 Divide-by-zero is detected when the prepared divisor equals 0.
REQ-024 Signed overflow is detected when op[0]=0 and the prepared divisor is all ones.
REQ-025 Overflow additionally requires the prepared dividend to be the most-negative value: 0x8000_0000_0000_0000, or for is_word the sign-extended value 0xFFFF_FFFF_8000_0000.
REQ-026 Special-case results: divide-by-zero gives quotient all ones and remainder = dividend; overflow gives quotient = dividend and remainder 0.
REQ-027 A special-case request SHALL go IDLE->DONE on accept, with out_valid high in the next cycle, and SHALL never assert dv_in_valid.
REQ-028 A normal request SHALL go IDLE->ISSUE.
REQ-029 In ISSUE, dv_in_valid SHALL be 1 for exactly one cycle, with dv_signed=~op[0]; the state then goes to WAIT.
REQ-030 dv_in_valid SHALL be 0 in every state other than ISSUE.
REQ-031 In WAIT, the block SHALL capture on the dv_out_valid cycle: dv_remainder if op[1]=1, else dv_quotient; the state then goes to DONE.
REQ-032 dv_out_valid outside WAIT SHALL be ignored.
REQ-033 Result formatting: if is_word=1, out_result = sign-extension of bit 31 of the selected value; otherwise out_result = the full 64-bit selected value.
REQ-034 In DONE, out_valid=1 and out_result SHALL be held stable until out_valid&out_ready.
REQ-035 On the out_valid&out_ready edge the state SHALL return to IDLE, so the next accept occurs no earlier than the following cycle.
REQ-036 Normal-path latency: accept edge T, dv_in_valid during cycle T+1, out_valid from the cycle after dv_out_valid (T+66 with the current 64-cycle divider); the design SHALL NOT depend on the divider latency.
REQ-037 No new request SHALL be accepted while the block is in ISSUE, WAIT or DONE; in_valid in those states has no effect.

Reset
REQ-038 reset SHALL force IDLE, in_ready=1, out_valid=0, dv_in_valid=0 and out_result=0, clearing all operand registers.
REQ-039 reset asserted mid-operation (ISSUE, WAIT or DONE) SHALL abandon the request without producing a result.
REQ-040 The divider SHALL share the same reset, so no stale dv_out_valid reaches a later request.

Verification
REQ-041 DIV -7 / 2 -> out_result 0xFFFF_FFFF_FFFF_FFFD; REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF; exactly one dv_in_valid pulse per request.
REQ-042 DIVU 0x1234 / 0 -> out_result 0xFFFF_FFFF_FFFF_FFFF one cycle after accept with dv_in_valid never high; REMU on the same operands -> 0x1234.
REQ-043 DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF -> 0x8000_0000_0000_0000; REM on the same operands -> 0; DIVW with src1 low 0x8000_0000 and src2 low 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
REQ-044 DIVW with src1=0x0000_0001_8000_0000, src2=2 -> 0xFFFF_FFFF_C000_0000; DIVUW on the same operands -> 0x0000_0000_4000_0000; the divider sees operand 0xFFFF_FFFF_8000_0000 and 0x8000_0000 respectively.
REQ-045 Hold out_ready=0 for 10 cycles in DONE -> out_result stable and in_ready=0 throughout; release -> in_ready=1 the next cycle and a back-to-back request completes correctly.
REQ-046 Assert reset during WAIT -> next cycle out_valid=0, in_ready=1; a following DIVU 100/7 -> 14.
